// File: rtl/mips_cycle_sequencer.sv
// mips_cycle_sequencer: multi-cycle FETCH/EXEC/MEM/WB control FSM for a MIPS core.
// Owns PC, instruction register, branch-delay-slot tracking, load-data latch and halt.
// Ports: clk, reset_n (async, active-low); Avalon-style bus master (address, read,
//   write, byteenable, writedata, readdata, waitrequest); datapath inputs (alu_result,
//   alu_byteenable, store_data, reg_write_req, pc_target, pc_target_valid); status
//   outputs (instr, pc, mem_rdata, reg_write_en, active, bus_error).
// Optional macro SEQ_WAIT_TIMEOUT_EN: bounds consecutive waitrequest cycles by
//   TIMEOUT_CYCLES, then flags bus_error and halts. Undefined: waits forever.
// Bus outputs are registered. The first fetch after reset spends one cycle raising
//   read; every later fetch is issued from WB, so an ALU op takes 3 cycles.

module mips_cycle_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
`ifdef SEQ_WAIT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_byteenable,
    input  logic [31:0] store_data,
    input  logic        reg_write_req,
    input  logic [31:0] pc_target,
    input  logic        pc_target_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] mem_rdata,
    output logic        reg_write_en,
    output logic        active,
    output logic        bus_error
);

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_EXEC  = 3'd1;
    localparam logic [2:0] ST_MEM   = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [31:0] branch_target_q, branch_target_d;
    logic        branch_seen_q, branch_seen_d;
    logic        armed_q, armed_d;

`ifdef SEQ_WAIT_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        bus_error_q, bus_error_d;
`endif

    logic [5:0]  opcode;
    logic        is_load;
    logic        is_store;
    logic [31:0] pc_next;

    assign opcode = instr_q[31:26];

    always_comb begin
        is_load = 1'b0;
        is_store = 1'b0;
        case (opcode)
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26: is_load = 1'b1;
            6'h28, 6'h29, 6'h2B: is_store = 1'b1;
            default: ;
        endcase
    end

    // Armed means the previous instruction was a taken branch and the
    // delay slot is now finishing, so the saved target takes effect.
    assign pc_next = armed_q ? branch_target_q : pc_q + 32'd4;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        mem_rdata_d     = mem_rdata_q;
        read_d          = read_q;
        write_d         = write_q;
        byteenable_d    = byteenable_q;
        address_d       = address_q;
        writedata_d     = writedata_q;
        branch_target_d = branch_target_q;
        branch_seen_d   = branch_seen_q;
        armed_d         = armed_q;
`ifdef SEQ_WAIT_TIMEOUT_EN
        wait_cnt_d      = 32'd0;
        bus_error_d     = bus_error_q;
`endif

        case (state_q)
            ST_FETCH: begin
                if (!read_q) begin
                    // Only reached right after reset: raise the fetch.
                    read_d       = 1'b1;
                    address_d    = pc_q & WORD_MASK;
                    byteenable_d = 4'hF;
                end else if (!waitrequest) begin
                    instr_d      = readdata;
                    read_d       = 1'b0;
                    byteenable_d = 4'h0;
                    state_d      = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (pc_target_valid && !armed_q) begin
                    branch_target_d = pc_target;
                    branch_seen_d   = 1'b1;
                end
                if (is_load || is_store) begin
                    state_d      = ST_MEM;
                    address_d    = alu_result & WORD_MASK;
                    byteenable_d = alu_byteenable;
                    read_d       = is_load;
                    write_d      = is_store;
                    if (is_store) begin
                        writedata_d = store_data;
                    end
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_MEM: begin
                if (!waitrequest) begin
                    if (read_q) begin
                        mem_rdata_d = readdata;
                    end
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    byteenable_d = 4'h0;
                    state_d      = ST_WB;
                end
            end

            ST_WB: begin
                pc_d          = pc_next;
                armed_d       = branch_seen_q;
                branch_seen_d = 1'b0;
                if (pc_next == 32'd0) begin
                    state_d = ST_HALT;
                end else begin
                    state_d      = ST_FETCH;
                    read_d       = 1'b1;
                    address_d    = pc_next & WORD_MASK;
                    byteenable_d = 4'hF;
                end
            end

            ST_HALT: begin
                read_d       = 1'b0;
                write_d      = 1'b0;
                byteenable_d = 4'h0;
            end

            default: begin
                state_d      = ST_HALT;
                read_d       = 1'b0;
                write_d      = 1'b0;
                byteenable_d = 4'h0;
            end
        endcase

`ifdef SEQ_WAIT_TIMEOUT_EN
        // Count only stalled cycles of an access actually on the bus; any
        // accepted cycle or state change leaves the counter at zero.
        if ((state_q == ST_FETCH || state_q == ST_MEM) &&
            (read_q || write_q) && waitrequest) begin
            if (wait_cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
                bus_error_d  = 1'b1;
                state_d      = ST_HALT;
                read_d       = 1'b0;
                write_d      = 1'b0;
                byteenable_d = 4'h0;
            end else begin
                wait_cnt_d = wait_cnt_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_FETCH;
            pc_q            <= RESET_VECTOR;
            instr_q         <= 32'd0;
            mem_rdata_q     <= 32'd0;
            read_q          <= 1'b0;
            write_q         <= 1'b0;
            byteenable_q    <= 4'h0;
            address_q       <= 32'd0;
            writedata_q     <= 32'd0;
            branch_target_q <= 32'd0;
            branch_seen_q   <= 1'b0;
            armed_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            mem_rdata_q     <= mem_rdata_d;
            read_q          <= read_d;
            write_q         <= write_d;
            byteenable_q    <= byteenable_d;
            address_q       <= address_d;
            writedata_q     <= writedata_d;
            branch_target_q <= branch_target_d;
            branch_seen_q   <= branch_seen_d;
            armed_q         <= armed_d;
        end
    end

`ifdef SEQ_WAIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q  <= 32'd0;
            bus_error_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error = bus_error_q;
`else
    assign bus_error = 1'b0;
`endif

    assign address      = address_q;
    assign read         = read_q;
    assign write        = write_q;
    assign byteenable   = byteenable_q;
    assign writedata    = writedata_q;
    assign instr        = instr_q;
    assign pc           = pc_q;
    assign mem_rdata    = mem_rdata_q;
    assign active       = (state_q != ST_HALT);
    // Stores never write the register file, whatever the decoder says.
    assign reg_write_en = (state_q == ST_WB) && reg_write_req && !is_store;

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// Directed bench for mips_cycle_sequencer: fetch, ALU op, load with waits,
// byte store, branch delay slot, halt on jump to 0, stalled bus and reset.

module tb_mips_cycle_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] alu_result;
    logic [3:0]  alu_byteenable;
    logic [31:0] store_data;
    logic        reg_write_req;
    logic [31:0] pc_target;
    logic        pc_target_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] mem_rdata;
    logic        reg_write_en;
    logic        active;
    logic        bus_error;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef SEQ_WAIT_TIMEOUT_EN
    mips_cycle_sequencer #(
        .RESET_VECTOR  (32'hBFC00000),
        .TIMEOUT_CYCLES(4)
    ) dut (
`else
    mips_cycle_sequencer #(
        .RESET_VECTOR(32'hBFC00000)
    ) dut (
`endif
        .clk            (clk),
        .reset_n        (reset_n),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .address        (address),
        .read           (read),
        .write          (write),
        .byteenable     (byteenable),
        .writedata      (writedata),
        .alu_result     (alu_result),
        .alu_byteenable (alu_byteenable),
        .store_data     (store_data),
        .reg_write_req  (reg_write_req),
        .pc_target      (pc_target),
        .pc_target_valid(pc_target_valid),
        .instr          (instr),
        .pc             (pc),
        .mem_rdata      (mem_rdata),
        .reg_write_en   (reg_write_en),
        .active         (active),
        .bus_error      (bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] a);
        chk({tag, "_read"}, {31'd0, read}, 32'd1);
        chk({tag, "_write"}, {31'd0, write}, 32'd0);
        chk({tag, "_addr"}, address, a);
        chk({tag, "_be"}, {28'd0, byteenable}, 32'hF);
    endtask

    initial begin
        reset_n         = 1'b0;
        waitrequest     = 1'b0;
        readdata        = 32'd0;
        alu_result      = 32'd0;
        alu_byteenable  = 4'h0;
        store_data      = 32'd0;
        reg_write_req   = 1'b0;
        pc_target       = 32'd0;
        pc_target_valid = 1'b0;
        step();
        step();

        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_be", {28'd0, byteenable}, 32'd0);
        chk("rst_wdata", writedata, 32'd0);
        chk("rst_pc", pc, 32'hBFC00000);
        chk("rst_instr", instr, 32'd0);
        chk("rst_mrd", mem_rdata, 32'd0);
        chk("rst_rwe", {31'd0, reg_write_en}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd1);
        chk("rst_berr", {31'd0, bus_error}, 32'd0);

        // ADDIU $2,$0,5 at the reset vector, no wait states
        reset_n       = 1'b1;
        readdata      = 32'h24020005;
        reg_write_req = 1'b1;
        step();
        chk_fetch("addiu_c1", 32'hBFC00000);
        step();
        chk("addiu_instr", instr, 32'h24020005);
        chk("addiu_c2_read", {31'd0, read}, 32'd0);
        chk("addiu_c2_rwe", {31'd0, reg_write_en}, 32'd0);
        step();
        chk("addiu_c3_rwe", {31'd0, reg_write_en}, 32'd1);
        chk("addiu_c3_pc", pc, 32'hBFC00000);
        step();
        chk("addiu_c4_pc", pc, 32'hBFC00004);
        chk("addiu_c4_rwe", {31'd0, reg_write_en}, 32'd0);
        chk_fetch("lw_fetch", 32'hBFC00004);

        // LW with unaligned ALU address and 2 wait states
        readdata       = 32'h8C820000;
        alu_result     = 32'h00001006;
        alu_byteenable = 4'hF;
        step();
        chk("lw_instr", instr, 32'h8C820000);
        readdata    = 32'hDEADBEEF;
        waitrequest = 1'b1;
        step();
        chk("lw_m1_read", {31'd0, read}, 32'd1);
        chk("lw_m1_addr", address, 32'h00001004);
        chk("lw_m1_be", {28'd0, byteenable}, 32'hF);
        step();
        chk("lw_m2_read", {31'd0, read}, 32'd1);
        chk("lw_m2_addr", address, 32'h00001004);
        chk("lw_m2_mrd", mem_rdata, 32'd0);
        step();
        chk("lw_m3_read", {31'd0, read}, 32'd1);
        chk("lw_m3_addr", address, 32'h00001004);
        waitrequest = 1'b0;
        readdata    = 32'h12345678;
        step();
        chk("lw_mrd", mem_rdata, 32'h12345678);
        chk("lw_wb_read", {31'd0, read}, 32'd0);
        chk("lw_wb_rwe", {31'd0, reg_write_en}, 32'd1);
        step();
        chk("lw_next_rwe", {31'd0, reg_write_en}, 32'd0);
        chk("lw_next_pc", pc, 32'hBFC00008);
        chk_fetch("sb_fetch", 32'hBFC00008);

        // SB; decoder request deliberately high, store must suppress it
        readdata = 32'hA0850000;
        step();
        chk("sb_instr", instr, 32'hA0850000);
        alu_result     = 32'h00002002;
        alu_byteenable = 4'b0100;
        store_data     = 32'hAABBCCDD;
        step();
        chk("sb_write", {31'd0, write}, 32'd1);
        chk("sb_read", {31'd0, read}, 32'd0);
        chk("sb_be", {28'd0, byteenable}, 32'h4);
        chk("sb_wdata", writedata, 32'hAABBCCDD);
        chk("sb_addr", address, 32'h00002000);
        step();
        chk("sb_wb_write", {31'd0, write}, 32'd0);
        chk("sb_wb_rwe", {31'd0, reg_write_en}, 32'd0);
        step();
        chk("sb_next_pc", pc, 32'hBFC0000C);
        chk_fetch("nop_fetch", 32'hBFC0000C);

        // NOP at 0xBFC0000C
        reg_write_req = 1'b0;
        readdata      = 32'h00000000;
        step();
        step();
        step();
        chk_fetch("br_fetch", 32'hBFC00010);

        // Branch at 0xBFC00010 to 0xBFC00100
        readdata = 32'h1000003B;
        step();
        pc_target       = 32'hBFC00100;
        pc_target_valid = 1'b1;
        step();
        pc_target_valid = 1'b0;
        step();
        chk("ds_pc", pc, 32'hBFC00014);
        chk_fetch("ds_fetch", 32'hBFC00014);

        // Delay slot holds another jump; its target must be ignored
        readdata = 32'h08000123;
        step();
        pc_target       = 32'hBFC00200;
        pc_target_valid = 1'b1;
        step();
        pc_target_valid = 1'b0;
        step();
        chk("tgt_pc", pc, 32'hBFC00100);
        chk_fetch("tgt_fetch", 32'hBFC00100);

        readdata = 32'h00000000;
        step();
        step();
        step();
        chk("after_tgt_pc", pc, 32'hBFC00104);
        chk_fetch("jr_fetch", 32'hBFC00104);

        // JR to 0, delay slot at 0xBFC00108, then halt
        readdata = 32'h03E00008;
        step();
        pc_target       = 32'h00000000;
        pc_target_valid = 1'b1;
        step();
        pc_target_valid = 1'b0;
        step();
        chk("jr_ds_pc", pc, 32'hBFC00108);
        chk_fetch("jr_ds_fetch", 32'hBFC00108);
        chk("jr_ds_active", {31'd0, active}, 32'd1);
        readdata = 32'h00000000;
        step();
        step();
        step();
        chk("halt_active", {31'd0, active}, 32'd0);
        chk("halt_read", {31'd0, read}, 32'd0);
        chk("halt_write", {31'd0, write}, 32'd0);
        chk("halt_pc", pc, 32'd0);
        step();
        step();
        chk("halt2_active", {31'd0, active}, 32'd0);
        chk("halt2_read", {31'd0, read}, 32'd0);
        chk("halt2_write", {31'd0, write}, 32'd0);

        // Restart, then memory stuck in waitrequest during fetch
        reset_n = 1'b0;
        step();
        reset_n     = 1'b1;
        waitrequest = 1'b1;
        readdata    = 32'h11111111;
        step();
        chk_fetch("stall_c1", 32'hBFC00000);
        step();
        step();
        step();
        step();
`ifdef SEQ_WAIT_TIMEOUT_EN
        chk("to_berr", {31'd0, bus_error}, 32'd1);
        chk("to_active", {31'd0, active}, 32'd0);
        chk("to_read", {31'd0, read}, 32'd0);
        step();
        chk("to2_berr", {31'd0, bus_error}, 32'd1);
        chk("to2_active", {31'd0, active}, 32'd0);
`else
        chk("stall_berr", {31'd0, bus_error}, 32'd0);
        chk("stall_active", {31'd0, active}, 32'd1);
        chk_fetch("stall_c5", 32'hBFC00000);
        chk("stall_instr", instr, 32'd0);
        step();
        step();
        chk_fetch("stall_c7", 32'hBFC00000);
        chk("stall_berr2", {31'd0, bus_error}, 32'd0);
`endif

        // Asynchronous reset in the middle of the stalled access
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_read", {31'd0, read}, 32'd0);
        chk("arst_berr", {31'd0, bus_error}, 32'd0);
        chk("arst_active", {31'd0, active}, 32'd1);
        chk("arst_pc", pc, 32'hBFC00000);
        step();
        reset_n     = 1'b1;
        waitrequest = 1'b0;
        readdata    = 32'h00000000;
        step();
        chk_fetch("refetch", 32'hBFC00000);
        step();
        chk("refetch_instr", instr, 32'h00000000);
        chk("refetch_read", {31'd0, read}, 32'd0);
        step();
        step();
        chk("refetch_pc", pc, 32'hBFC00004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
